// File: rtl/riscv_pc_pkg.sv
// Shared defaults and target-select encoding for the RISC-V program-counter sequencer.
package riscv_pc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
    localparam int          RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_PEND,
        SEL_TRAP
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop and push+pop replace of the top entry.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_idx;
    logic             replace;

    assign empty   = (count == '0);
    assign top     = empty ? '0 : mem[ptr];
    // Replace on an empty stack degenerates to a plain push.
    assign replace = push && pop && !empty;
    assign wr_idx  = replace ? ptr : ptr + PTR_W'(1);

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !replace) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (pop && !push && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // NOTE: the entry array has no reset; count gates visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jal/jalr target select, fetch handshake,
// pending redirect latch, misaligned-target trap and return-address stack.
module pc_sequencer
    import riscv_pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(TRAP_PC_DEF),
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_imm,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_base,
    input  logic            link,
    input  logic            ret,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            trap,
    output logic [XLEN-1:0] epc
);

    logic            advance;
    logic            redirect;
    logic            misaligned;
    logic            pend_valid;
    logic [XLEN-1:0] pend_addr;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    pc_sel_e         sel;

    assign advance     = fetch_valid && fetch_ready && !stall;
    assign redirect    = jalr || jal || br_taken;
    assign pc_plus4    = pc + XLEN'(4);
    assign br_target   = pc + (br_imm << 1);
    assign jalr_sum    = jalr_base + br_imm;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel    = SEL_SEQ;
        target = pend_addr;
        if (jalr) begin
            sel    = SEL_JALR;
            target = jalr_target;
        end else if (jal) begin
            sel    = SEL_JAL;
            target = br_target;
        end else if (br_taken) begin
            sel    = SEL_BR;
            target = br_target;
        end else if (pend_valid) begin
            sel    = SEL_PEND;
        end
        // No compressed instructions, so any redirect off a word boundary traps.
        if (sel != SEL_SEQ && target[1:0] != 2'b00)
            sel = SEL_TRAP;

        case (sel)
            SEL_SEQ:  next_pc = pc_plus4;
            SEL_TRAP: next_pc = TRAP_PC;
            default:  next_pc = target;
        endcase
    end

    assign misaligned = (sel == SEL_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            trap        <= 1'b0;
            epc         <= '0;
        end else begin
            fetch_valid <= 1'b1;
            trap        <= 1'b0;
            if (advance) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
                if (misaligned) begin
                    trap <= 1'b1;
                    epc  <= pc;
                end
            end else if (redirect) begin
                // Held redirect: newest one wins, applied on the next advancing edge.
                pend_valid <= 1'b1;
                pend_addr  <= target;
            end
        end
    end

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (advance && !misaligned && link),
        .pop       (advance && !misaligned && ret),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRP_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, br_taken, jal, jalr, link, ret;
    logic [31:0] br_imm, jalr_base;
    logic        fetch_valid, ras_empty, trap;
    logic [31:0] pc, pc_plus4, ras_top, epc;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN      (32),
        .RESET_PC  (RST_PC),
        .TRAP_PC   (TRP_PC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .jal         (jal),
        .jalr        (jalr),
        .jalr_base   (jalr_base),
        .link        (link),
        .ret         (ret),
        .ras_top     (ras_top),
        .ras_empty   (ras_empty),
        .trap        (trap),
        .epc         (epc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural view, RAS kept as a queue of return addresses.
    logic [31:0] m_pc, m_epc, m_pa;
    bit          m_fv, m_pv, m_trap;
    logic [31:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit fr, input bit bt, input logic [31:0] imm,
                         input bit j, input bit jr, input logic [31:0] base, input bit lk, input bit rt);
        reset = r; stall = st; fetch_ready = fr; br_taken = bt; br_imm = imm;
        jal = j; jalr = jr; jalr_base = base; link = lk; ret = rt;
    endtask

    // Advance the model by one edge from the current inputs.
    task automatic model_edge();
        bit          adv, has_redir, use_tgt;
        logic [31:0] tgt, nxt4;
        adv       = m_fv && fetch_ready && !stall;
        has_redir = jalr || jal || br_taken;
        nxt4      = m_pc + 32'd4;
        if (jalr)                 tgt = (jalr_base + br_imm) & 32'hFFFF_FFFE;
        else if (jal || br_taken) tgt = m_pc + br_imm * 2;
        else                      tgt = m_pa;
        use_tgt = has_redir || m_pv;
        if (reset) begin
            m_pc = RST_PC; m_fv = 0; m_pv = 0; m_pa = '0; m_trap = 0; m_epc = '0;
            m_ras.delete();
            return;
        end
        m_fv   = 1;
        m_trap = 0;
        if (adv) begin
            m_pv = 0;
            if (use_tgt && (tgt % 4 != 0)) begin
                m_trap = 1;
                m_epc  = m_pc;
                m_pc   = TRP_PC;
            end else begin
                m_pc = use_tgt ? tgt : nxt4;
                if (link && ret) begin
                    if (m_ras.size() == 0) m_ras.push_back(nxt4);
                    else m_ras[m_ras.size()-1] = nxt4;
                end else if (link) begin
                    m_ras.push_back(nxt4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (ret) begin
                    if (m_ras.size() != 0) void'(m_ras.pop_back());
                end
            end
        end else if (has_redir) begin
            m_pv = 1;
            m_pa = tgt;
        end
    endtask

    task automatic step();
        logic [31:0] exp_top;
        model_edge();
        @(posedge clk);
        #1;
        exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
        check("pc",          pc,          m_pc);
        check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        check("trap",        {31'b0, trap},        {31'b0, m_trap});
        check("epc",         epc,         m_epc);
        check("ras_top",     ras_top,     exp_top);
        check("ras_empty",   {31'b0, ras_empty},   {31'b0, m_ras.size() == 0});
    endtask

    // Plain advancing cycle.
    task automatic seq();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    // Move pc to an aligned address via a non-linking jalr.
    task automatic goto(input logic [31:0] addr);
        drive(0, 0, 1, 0, 0, 0, 1, addr, 0, 0);
        step();
    endtask

    task automatic do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("fv_in_reset", {31'b0, fetch_valid}, 32'h0);
    endtask

    logic [31:0] exp_seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        m_pc = '0; m_epc = '0; m_pa = '0; m_fv = 0; m_pv = 0; m_trap = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // 1: reset then free-running fetch
        do_reset();
        do_reset();
        check("reset_pc", pc, RST_PC);
        for (int i = 0; i < 4; i++) begin
            seq();
            check("seq_pc", pc, exp_seq[i]);
        end
        check("fv_high", {31'b0, fetch_valid}, 32'h1);

        // 2: backward branch and wrapping misaligned branch
        goto(32'h20);
        drive(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        step();
        check("br_back", pc, 32'h18);
        goto(32'h4);
        drive(0, 0, 1, 1, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        step();
        check("br_wrap_trap", {31'b0, trap}, 32'h1);
        check("br_wrap_pc", pc, TRP_PC);
        check("br_wrap_epc", epc, 32'h4);
        seq();
        check("trap_pulse", {31'b0, trap}, 32'h0);

        // 3: redirect under stall lands in the pending latch
        goto(32'h40);
        drive(0, 1, 1, 1, 32'h8, 0, 0, 0, 0, 0);
        step();
        check("stall_hold", pc, 32'h40);
        seq();
        check("pend_apply", pc, 32'h50);
        seq();
        check("pend_clear", pc, 32'h54);

        // 4: jalr alignment
        drive(0, 0, 1, 0, 0, 0, 1, 32'h103, 0, 0);
        step();
        check("jalr_mis_trap", {31'b0, trap}, 32'h1);
        check("jalr_mis_epc", epc, 32'h54);
        drive(0, 0, 1, 0, 0, 0, 1, 32'h101, 0, 0);
        step();
        check("jalr_bit0", pc, 32'h100);
        check("jalr_no_trap", {31'b0, trap}, 32'h0);

        // 5: RAS overflow, underflow and replace
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            goto(32'h10 * i);
            drive(0, 0, 1, 0, 32'h40, 1, 0, 0, 1, 0);
            step();
        end
        check("ras_full_top", ras_top, 32'h54);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0, 1, ras_top, 0, 1);
            step();
        end
        check("ras_underflow", {31'b0, ras_empty}, 32'h1);
        goto(32'h60);
        drive(0, 0, 1, 0, 0, 0, 1, 32'h200, 1, 1);
        step();
        check("ras_replace_empty", ras_top, 32'h64);

        // 6: reset overrides pending redirect and a populated RAS
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 32'h20, 1, 0, 0, 1, 0);
            step();
        end
        drive(0, 1, 1, 1, 32'h80, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("rst_pc", pc, RST_PC);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        seq();
        seq();
        check("rst_pend_drop", pc, 32'h4);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit          r, st, fr, bt, j, jr, lk, rt;
            logic [31:0] imm, base;
            int          kind;
            r    = ($urandom_range(0, 63) == 0);
            st   = ($urandom_range(0, 3) == 0);
            fr   = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 5);
            bt   = (kind == 1) || ($urandom_range(0, 7) == 0);
            j    = (kind == 2);
            jr   = (kind == 3) || (kind == 4);
            imm  = $urandom_range(0, 511) - 256;
            if ($urandom_range(0, 7) != 0) imm = imm & 32'hFFFF_FFFE;
            base = ras_top;
            if (kind == 3) base = $urandom & 32'h0000_0FFF;
            if (kind == 4 && $urandom_range(0, 1) == 0) base = 32'h400;
            if ($urandom_range(0, 7) != 0) base = base & 32'hFFFF_FFFC;
            lk = (j || jr) && ($urandom_range(0, 1) == 0);
            rt = jr && ($urandom_range(0, 1) == 0);
            drive(r, st, fr, bt, imm, j, jr, base, lk, rt);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
